// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the packet-granular AXI4-Stream round-robin arbiter.
package axis_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_N_PORTS    = 4;
  localparam int DEF_ID_WIDTH   = 2;
  localparam int DEF_MAX_BEATS  = 256;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational circular find-first: lowest set req bit at or after start, wrapping.
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int N_PORTS  = DEF_N_PORTS,
  parameter int ID_WIDTH = DEF_ID_WIDTH
) (
  input  logic [N_PORTS-1:0]  req,
  input  logic [ID_WIDTH-1:0] start,
  output logic                found,
  output logic [ID_WIDTH-1:0] idx
);

  localparam int W2 = 2 * N_PORTS;

  logic [W2-1:0] dbl_req;
  logic [W2-1:0] start_mask;
  logic [W2-1:0] masked;

  // Upper copy of req covers the wrap; indices above N_PORTS fold back by subtraction.
  always_comb begin
    dbl_req    = {req, req};
    start_mask = {W2{1'b1}} << start;
    masked     = dbl_req & start_mask;
    found      = |req;
    idx        = '0;
    for (int i = W2 - 1; i >= 0; i--) begin
      if (masked[i]) idx = (i >= N_PORTS) ? ID_WIDTH'(i - N_PORTS) : ID_WIDTH'(i);
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI4-Stream sink between N_PORTS sources;
// grant held from first beat to tlast, source index on m_tid, oversize packets cut at MAX_BEATS.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_PORTS    = DEF_N_PORTS,
  parameter int ID_WIDTH   = DEF_ID_WIDTH,
  parameter int MAX_BEATS  = DEF_MAX_BEATS
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [N_PORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [N_PORTS-1:0]            s_tvalid,
  input  logic [N_PORTS-1:0]            s_tlast,
  output logic [N_PORTS-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic [ID_WIDTH-1:0]           m_tid,
  output logic                          m_tlast,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          busy,
  output logic                          err_oversize,
  input  logic                          err_clr
);

  localparam int CNT_W = clog2(MAX_BEATS);

  arb_state_t          state_reg, state_next;
  logic [ID_WIDTH-1:0] grant_reg, grant_next;
  logic [ID_WIDTH-1:0] rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]    beat_cnt_reg, beat_cnt_next;
  logic                err_reg, err_next;

  logic [ID_WIDTH-1:0]   grant_inc;
  logic [ID_WIDTH-1:0]   pick_start;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  pick_found;
  logic [N_PORTS-1:0]    pick_req;
  logic [N_PORTS-1:0]    own_mask;
  logic                  sel_tvalid;
  logic                  sel_tlast;
  logic [DATA_WIDTH-1:0] sel_tdata;
  logic                  at_limit;
  logic                  force_cut;
  logic                  accept;

  assign grant_inc  = (grant_reg == ID_WIDTH'(N_PORTS - 1)) ? '0 : grant_reg + 1'b1;
  assign sel_tvalid = s_tvalid[grant_reg];
  assign sel_tlast  = s_tlast[grant_reg];
  assign sel_tdata  = s_tdata[grant_reg*DATA_WIDTH +: DATA_WIDTH];
  assign at_limit   = (beat_cnt_reg == CNT_W'(MAX_BEATS - 1));
  assign force_cut  = at_limit & ~sel_tlast;

  always_comb begin
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tdata  = '0;
    m_tid    = '0;
    s_tready = '0;
    if (state_reg == ARB_BUSY) begin
      m_tvalid            = sel_tvalid;
      m_tlast             = sel_tlast | at_limit;
      m_tdata             = sel_tdata;
      m_tid               = grant_reg;
      s_tready[grant_reg] = m_tready;
    end
  end

  assign accept = m_tvalid & m_tready;

  // At end of packet the finishing port's tvalid still shows its last beat, not a new
  // request, so it is excluded; a genuine follow-on request is picked up from IDLE.
  always_comb begin
    own_mask            = '0;
    own_mask[grant_reg] = 1'b1;
  end

  assign pick_req   = (state_reg == ARB_BUSY) ? (s_tvalid & ~own_mask) : s_tvalid;
  assign pick_start = (state_reg == ARB_IDLE) ? rr_ptr_reg : grant_inc;

  rr_pick #(
    .N_PORTS  (N_PORTS),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req   (pick_req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    rr_ptr_next   = rr_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    err_next      = err_reg;
    if (err_clr) err_next = 1'b0;
    case (state_reg)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_next    = pick_idx;
          beat_cnt_next = '0;
          state_next    = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (accept) begin
          if (force_cut) err_next = 1'b1;
          if (m_tlast) begin
            rr_ptr_next   = grant_inc;
            beat_cnt_next = '0;
            if (pick_found) grant_next = pick_idx;
            else            state_next = ARB_IDLE;
          end else begin
            beat_cnt_next = beat_cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg    <= ARB_IDLE;
      grant_reg    <= '0;
      rr_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      rr_ptr_reg   <= rr_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
      err_reg      <= err_next;
    end
  end

  assign busy         = (state_reg == ARB_BUSY);
  assign err_oversize = err_reg;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scenario bench for axis_rr_arbiter: per-port source queues drive the inputs and a
// per-port scoreboard checks every accepted beat's data, tlast and source order.
module tb_axis_rr_arbiter;

  localparam int DW  = 32;
  localparam int NP  = 4;
  localparam int IDW = 2;
  localparam int MB  = 4;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic [NP*DW-1:0] s_tdata;
  logic [NP-1:0]    s_tvalid;
  logic [NP-1:0]    s_tlast;
  logic [NP-1:0]    s_tready;
  logic [DW-1:0]    m_tdata;
  logic [IDW-1:0]   m_tid;
  logic             m_tlast;
  logic             m_tvalid;
  logic             m_tready;
  logic             busy;
  logic             err_oversize;
  logic             err_clr;

  always #5 aclk = ~aclk;

  axis_rr_arbiter #(
    .DATA_WIDTH (DW),
    .N_PORTS    (NP),
    .ID_WIDTH   (IDW),
    .MAX_BEATS  (MB)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tlast      (s_tlast),
    .s_tready     (s_tready),
    .m_tdata      (m_tdata),
    .m_tid        (m_tid),
    .m_tlast      (m_tlast),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .busy         (busy),
    .err_oversize (err_oversize),
    .err_clr      (err_clr)
  );

  // {last, data}: source queue carries the source tlast, scoreboard the expected m_tlast
  logic [DW:0] src_q[NP][$];
  logic [DW:0] exp_q[NP][$];

  int checks = 0;
  int errors = 0;
  int beats_in = 0;
  int beats_out = 0;
  int cycle = 0;
  logic rdy = 1'b1;
  logic clr = 1'b0;

  logic           obs_m_tvalid, obs_m_tlast, obs_busy, obs_err, obs_acc;
  logic [IDW-1:0] obs_m_tid;
  logic [NP-1:0]  obs_s_tready;
  logic [DW-1:0]  obs_m_tdata;

  task automatic push_pkt(input int port, input int n, input logic [DW-1:0] base);
    logic last, exp_last;
    for (int k = 0; k < n; k++) begin
      last     = (k == n - 1);
      exp_last = last || ((k % MB) == MB - 1);
      src_q[port].push_back({last, base + DW'(k)});
      exp_q[port].push_back({exp_last, base + DW'(k)});
    end
  endtask

  task automatic step();
    logic [DW:0]   head;
    logic [DW:0]   exp_e;
    logic [NP-1:0] one_hot;
    @(negedge aclk);
    for (int i = 0; i < NP; i++) begin
      if (src_q[i].size() > 0) begin
        head                 = src_q[i][0];
        s_tvalid[i]          = 1'b1;
        s_tlast[i]           = head[DW];
        s_tdata[i*DW +: DW]  = head[DW-1:0];
      end else begin
        s_tvalid[i]          = 1'b0;
        s_tlast[i]           = 1'b0;
        s_tdata[i*DW +: DW]  = '0;
      end
    end
    m_tready = rdy;
    err_clr  = clr;
    #1;
    obs_m_tvalid = m_tvalid;
    obs_m_tlast  = m_tlast;
    obs_m_tid    = m_tid;
    obs_m_tdata  = m_tdata;
    obs_busy     = busy;
    obs_err      = err_oversize;
    obs_s_tready = s_tready;
    obs_acc      = m_tvalid & m_tready;
    for (int i = 0; i < NP; i++) begin
      if (s_tvalid[i] && s_tready[i]) begin
        void'(src_q[i].pop_front());
        beats_in++;
      end
    end
    if (obs_acc) begin
      beats_out++;
      checks++;
      if (exp_q[m_tid].size() == 0) begin
        errors++;
        $display("FAIL sb_extra port=%0d got=%h required none", m_tid, m_tdata);
      end else begin
        exp_e = exp_q[m_tid].pop_front();
        if ({m_tlast, m_tdata} !== exp_e) begin
          errors++;
          $display("FAIL sb_beat port=%0d got last=%b data=%h required last=%b data=%h",
                   m_tid, m_tlast, m_tdata, exp_e[DW], exp_e[DW-1:0]);
        end
      end
      $display("beat cyc=%0d port=%0d data=%h last=%b", cycle, m_tid, m_tdata, m_tlast);
    end
    if (busy) begin
      one_hot        = '0;
      one_hot[m_tid] = 1'b1;
      checks++;
      if ((s_tready & ~one_hot) !== '0) begin
        errors++;
        $display("FAIL tready_onehot got=%b grant=%0d", s_tready, m_tid);
      end
    end
    cycle++;
  endtask

  task automatic test_reset();
    rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({obs_m_tvalid, obs_busy, obs_s_tready, obs_err} !== '0) begin
        errors++;
        $display("FAIL reset_outputs got valid=%b busy=%b tready=%b err=%b required 0",
                 obs_m_tvalid, obs_busy, obs_s_tready, obs_err);
      end
    end
    @(negedge aclk);
    aresetn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if ({obs_m_tvalid, obs_busy, obs_s_tready} !== '0) begin
        errors++;
        $display("FAIL idle_outputs cyc=%0d got valid=%b busy=%b tready=%b required 0",
                 cycle, obs_m_tvalid, obs_busy, obs_s_tready);
      end
    end
  endtask

  task automatic test_single_port();
    push_pkt(2, 3, 32'h0000_00A0);
    step();
    checks++;
    if (obs_m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_latency got m_tvalid=%b required 0", obs_m_tvalid);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (obs_m_tvalid !== 1'b1 || obs_m_tid !== 2'd2 || obs_m_tlast !== (k == 2)) begin
        errors++;
        $display("FAIL single_beat%0d got valid=%b tid=%0d last=%b required 1 2 %b",
                 k, obs_m_tvalid, obs_m_tid, obs_m_tlast, (k == 2));
      end
    end
    step();
    checks++;
    if (obs_busy !== 1'b0 || obs_m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got busy=%b valid=%b required 0 0", obs_busy, obs_m_tvalid);
    end
  endtask

  task automatic test_reset_mid();
    push_pkt(0, 3, 32'h0000_0E00);
    step();
    step();
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    checks++;
    if ({m_tvalid, busy, s_tready} !== '0) begin
      errors++;
      $display("FAIL reset_mid got valid=%b busy=%b tready=%b required 0",
               m_tvalid, busy, s_tready);
    end
    src_q[0].delete();
    exp_q[0].delete();
    step();
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic test_round_robin();
    int first_cyc, last_cyc, exp_port, out0;
    logic new_pkt;
    for (int p = 0; p < 50; p++) begin
      for (int port = 0; port < NP; port++) begin
        push_pkt(port, 2, DW'(port * 32'h10000 + p * 16));
      end
    end
    first_cyc = -1;
    last_cyc  = -1;
    exp_port  = 0;
    new_pkt   = 1'b1;
    out0      = beats_out;
    for (int c = 0; c < 1000 && (beats_out - out0) < 400; c++) begin
      step();
      if (obs_acc) begin
        if (first_cyc < 0) first_cyc = cycle;
        last_cyc = cycle;
        if (new_pkt) begin
          checks++;
          if (obs_m_tid !== IDW'(exp_port)) begin
            errors++;
            $display("FAIL rr_order got=%0d required=%0d", obs_m_tid, exp_port);
          end
          exp_port = (exp_port + 1) % NP;
        end
        new_pkt = obs_m_tlast;
      end
    end
    checks++;
    if ((beats_out - out0) != 400) begin
      errors++;
      $display("FAIL rr_beats got=%0d required=400", beats_out - out0);
    end
    checks++;
    if (last_cyc - first_cyc + 1 != 400) begin
      errors++;
      $display("FAIL rr_cycles got=%0d required=400", last_cyc - first_cyc + 1);
    end
    step();
  endtask

  task automatic test_no_preempt();
    logic [2:0] pat;
    pat = 3'b101;
    push_pkt(1, 3, 32'h0000_00B0);
    step();
    push_pkt(0, 2, 32'h0000_00C0);
    for (int k = 0; k < 4; k++) begin
      rdy = (k < 3) ? pat[k] : 1'b1;
      step();
      checks++;
      if (obs_m_tid !== 2'd1 || obs_m_tvalid !== 1'b1 || obs_s_tready[0] !== 1'b0) begin
        errors++;
        $display("FAIL hold_p1 step=%0d got tid=%0d valid=%b tready0=%b required 1 1 0",
                 k, obs_m_tid, obs_m_tvalid, obs_s_tready[0]);
      end
    end
    step();
    checks++;
    if (obs_m_tid !== 2'd0 || obs_m_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL p0_after_tlast got tid=%0d valid=%b required 0 1", obs_m_tid, obs_m_tvalid);
    end
    step();
    step();
  endtask

  task automatic test_oversize();
    push_pkt(3, 6, 32'h0000_00D0);
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (obs_m_tlast !== (k == 3) || obs_m_tid !== 2'd3) begin
        errors++;
        $display("FAIL cut_beat%0d got last=%b tid=%0d required %b 3",
                 k, obs_m_tlast, obs_m_tid, (k == 3));
      end
    end
    step();
    checks++;
    if (obs_err !== 1'b1 || obs_busy !== 1'b0) begin
      errors++;
      $display("FAIL err_set got err=%b busy=%b required 1 0", obs_err, obs_busy);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if (obs_err !== 1'b1 || obs_acc !== 1'b1) begin
      errors++;
      $display("FAIL err_hold got err=%b acc=%b required 1 1", obs_err, obs_acc);
    end
    step();
    checks++;
    if (obs_err !== 1'b0 || obs_m_tlast !== 1'b1) begin
      errors++;
      $display("FAIL err_clear got err=%b last=%b required 0 1", obs_err, obs_m_tlast);
    end
    step();
  endtask

  initial begin
    s_tdata  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b0;
    err_clr  = 1'b0;
    test_reset();
    test_single_port();
    test_reset_mid();
    test_round_robin();
    test_no_preempt();
    test_oversize();
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (exp_q[i].size() != 0 || src_q[i].size() != 0) begin
        errors++;
        $display("FAIL drained port=%0d got exp=%0d src=%0d required 0 0",
                 i, exp_q[i].size(), src_q[i].size());
      end
    end
    checks++;
    if (beats_in != beats_out) begin
      errors++;
      $display("FAIL beat_sum got out=%0d required in=%0d", beats_out, beats_in);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
